pwm_multi: RTL and testbench



---
 rtl/pwm_multi.sv | 180 ++++++++++++++++++
 tb/tb_pwm_multi.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// ---------------------------------------------------------------------------
// pwm_multi
//
// Multi-channel PWM generator. One shared period counter feeds CHANNELS
// comparators. Each channel has a shadow duty register written by software
// and an active duty register that is only refreshed at a period boundary,
// so a duty change never produces a runt or stretched pulse.
//
// Counting modes (chosen per period, sampled at the boundary):
//   edge-aligned   : 0,1,...,MAX,0            period 2^WIDTH cycles
//   center-aligned : 0,1,...,MAX,MAX-1,...,1,0  period 2*MAX cycles
//
// Optional feature: define PWM_PHASE_STAGGER_EN to offset channel i by
// i*(2^WIDTH/CHANNELS) counts in edge mode. Each channel then reloads its
// active duty on its own local wrap. Center mode ignores the stagger.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   en           run enable; low parks the counter at 0 and forces outputs low
//   center_mode  0 = edge-aligned, 1 = center-aligned (takes effect at boundary)
//   duty_flat    duty per channel, channel i = bits [i*WIDTH +: WIDTH]
//   duty_load    one-cycle strobe capturing duty_flat into the shadow registers
//   dout         registered PWM outputs, one per channel
//   period_end   registered pulse aligned with the last output cycle of a period
// ---------------------------------------------------------------------------
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      center_mode,
    input  logic [CHANNELS*WIDTH-1:0] duty_flat,
    input  logic                      duty_load,
    output logic [CHANNELS-1:0]       dout,
    output logic                      period_end
);

    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Center mode needs MAX-1 to differ from 1 and 0.
    if (WIDTH < 2) begin : gWidthCheck
        $error("pwm_multi: WIDTH must be at least 2");
    end
    if (CHANNELS < 1) begin : gChanCheck
        $error("pwm_multi: CHANNELS must be at least 1");
    end

`ifdef PWM_PHASE_STAGGER_EN
    localparam int STEP = (2 ** WIDTH) / CHANNELS;

    if (((CHANNELS & (CHANNELS - 1)) != 0) || (CHANNELS > 2 ** WIDTH)) begin : gStaggerCheck
        $error("pwm_multi: CHANNELS must be a power of two no greater than 2^WIDTH");
    end
`endif

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    dir_e                dir_q, dir_d;
    logic                modeActive_q, modeActive_d;
    logic [CHANNELS-1:0] dout_q, dout_d;
    logic                periodEnd_q, periodEnd_d;
    logic                boundary;
    logic [CHANNELS-1:0] raw;

    // The period ends on the last count of the period: MAX in edge mode,
    // 1 on the way down in center mode.
    always_comb begin
        if (modeActive_q) begin
            boundary = (dir_q == DIR_DOWN) && (cnt_q == ONE);
        end else begin
            boundary = (cnt_q == MAX);
        end
    end

    // Shared counter. While disabled it is parked at 0 counting up and keeps
    // tracking center_mode, so the first enabled period starts cleanly.
    // In center mode MAX is visited once: the turn-around happens on the
    // edge that leaves MAX.
    always_comb begin
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        modeActive_d = modeActive_q;
        if (!en || boundary) begin
            cnt_d        = ZERO;
            dir_d        = DIR_UP;
            modeActive_d = center_mode;
        end else if (modeActive_q) begin
            if (dir_q == DIR_DOWN) begin
                cnt_d = cnt_q - ONE;
            end else if (cnt_q == MAX) begin
                cnt_d = cnt_q - ONE;
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : gChan
        logic [WIDTH-1:0] shadow_q, shadow_d;
        logic [WIDTH-1:0] active_q, active_d;
        logic [WIDTH-1:0] dutyIn;
        logic [WIDTH-1:0] lcnt;
        logic             chanBoundary;

        assign dutyIn = duty_flat[i*WIDTH +: WIDTH];

`ifdef PWM_PHASE_STAGGER_EN
        localparam logic [WIDTH-1:0] OFFS = WIDTH'(i * STEP);

        // Edge mode: each channel sees its own rotated count and reloads on
        // its own wrap; the addition wraps naturally at WIDTH bits.
        assign lcnt         = modeActive_q ? cnt_q : (cnt_q + OFFS);
        assign chanBoundary = modeActive_q ? boundary : (lcnt == MAX);
`else
        assign lcnt         = cnt_q;
        assign chanBoundary = boundary;
`endif

        // A load that lands on the reload edge bypasses the shadow so the new
        // duty applies to the period that starts on that very edge.
        always_comb begin
            shadow_d = duty_load ? dutyIn : shadow_q;
            active_d = active_q;
            if (!en || chanBoundary) begin
                active_d = duty_load ? dutyIn : shadow_q;
            end
        end

        // Full-scale duty saturates high so MAX means "always on" rather
        // than leaving a one-count low gap at cnt == MAX.
        assign raw[i] = (active_q == MAX) || (lcnt < active_q);

        always_ff @(posedge clk) begin
            if (rst) begin
                shadow_q <= ZERO;
                active_q <= ZERO;
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
            end
        end
    end

    always_comb begin
        dout_d      = en ? raw : '0;
        periodEnd_d = en && boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= ZERO;
            dir_q        <= DIR_UP;
            modeActive_q <= 1'b0;
            dout_q       <= '0;
            periodEnd_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            modeActive_q <= modeActive_d;
            dout_q       <= dout_d;
            periodEnd_q  <= periodEnd_d;
        end
    end

    assign dout       = dout_q;
    assign period_end = periodEnd_q;

endmodule

// File: tb/tb_pwm_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi
//
// Self-checking bench for pwm_multi (WIDTH=8, CHANNELS=4): a short vector
// table for reset/enable start-up, hand sequences for whole-period cadence,
// duty reload timing, center mode, enable drop and mid-period reset, then a
// randomized run checked cycle by cycle against a position-based model.
// ---------------------------------------------------------------------------
module tb_pwm_multi;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int MAXV     = (1 << WIDTH) - 1;
`ifdef PWM_PHASE_STAGGER_EN
    localparam bit STAGGER = 1'b1;
`else
    localparam bit STAGGER = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic                      center_mode;
    logic [CHANNELS*WIDTH-1:0] duty_flat;
    logic                      duty_load;
    logic [CHANNELS-1:0]       dout;
    logic                      period_end;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_multi #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .center_mode(center_mode),
        .duty_flat  (duty_flat),
        .duty_load  (duty_load),
        .dout       (dout),
        .period_end (period_end)
    );

    // Reference model: tracks the position inside the current period and
    // derives the count from it, rather than stepping a direction flag.
    int                  mPos;
    bit                  mMode;
    int                  mShadow[CHANNELS];
    int                  mActive[CHANNELS];
    logic [CHANNELS-1:0] expDout;
    logic                expPe;

    function automatic int periodLen(bit center);
        return center ? 2 * MAXV : MAXV + 1;
    endfunction

    function automatic int posToCnt(int pos, bit center);
        if (center && pos > MAXV) return 2 * MAXV - pos;
        return pos;
    endfunction

    function automatic int localCount(int cnt, int ch, bit center);
        if (STAGGER && !center) return (cnt + ch * ((MAXV + 1) / CHANNELS)) % (MAXV + 1);
        return cnt;
    endfunction

    function automatic int dutyOf(int ch);
        return int'(duty_flat[ch*WIDTH +: WIDTH]);
    endfunction

    // Evaluated right after each rising edge with the inputs that edge saw;
    // produces the outputs the DUT should now present.
    task automatic modelEdge();
        int  cnt;
        int  lc;
        bit  last;
        bit  upd;
        if (rst) begin
            mPos    = 0;
            mMode   = 1'b0;
            expDout = '0;
            expPe   = 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                mShadow[i] = 0;
                mActive[i] = 0;
            end
        end else if (!en) begin
            expDout = '0;
            expPe   = 1'b0;
            mPos    = 0;
            mMode   = center_mode;
            for (int i = 0; i < CHANNELS; i++) begin
                mActive[i] = duty_load ? dutyOf(i) : mShadow[i];
                if (duty_load) mShadow[i] = dutyOf(i);
            end
        end else begin
            cnt   = posToCnt(mPos, mMode);
            last  = (mPos == periodLen(mMode) - 1);
            expPe = last;
            for (int i = 0; i < CHANNELS; i++) begin
                lc         = localCount(cnt, i, mMode);
                expDout[i] = (mActive[i] == MAXV) || (lc < mActive[i]);
                upd        = (STAGGER && !mMode) ? (lc == MAXV) : last;
                if (upd) mActive[i] = duty_load ? dutyOf(i) : mShadow[i];
                if (duty_load) mShadow[i] = dutyOf(i);
            end
            if (last) begin
                mPos  = 0;
                mMode = center_mode;
            end else begin
                mPos++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(bit r, bit e, bit l, logic [31:0] d);
        rst       = r;
        en        = e;
        duty_load = l;
        duty_flat = d;
        tick();
    endtask

    int hiCnt[CHANNELS];
    int peCnt;
    int peIdx;

    // Runs len cycles starting at a period start; optionally pulses
    // duty_load on the edge whose pre-edge count index is loadAt.
    task automatic runPeriod(int len, int loadAt, logic [31:0] loadDuty);
        for (int i = 0; i < CHANNELS; i++) hiCnt[i] = 0;
        peCnt = 0;
        peIdx = -1;
        for (int j = 0; j < len; j++) begin
            if (j == loadAt) begin
                duty_flat = loadDuty;
                duty_load = 1'b1;
            end
            tick();
            duty_load = 1'b0;
            for (int i = 0; i < CHANNELS; i++) if (dout[i] === 1'b1) hiCnt[i]++;
            if (period_end === 1'b1) begin
                peCnt++;
                peIdx = j;
            end
        end
    endtask

    task automatic checkPeriod(string tag, int len, int e0, int e1, int e2, int e3);
        checkOutput({tag, " ch0 highs"}, hiCnt[0], e0);
        checkOutput({tag, " ch1 highs"}, hiCnt[1], e1);
        checkOutput({tag, " ch2 highs"}, hiCnt[2], e2);
        checkOutput({tag, " ch3 highs"}, hiCnt[3], e3);
        checkOutput({tag, " pe count"}, peCnt, 1);
        checkOutput({tag, " pe index"}, peIdx, len - 1);
    endtask

    task automatic syncToBoundary(int limit);
        int n = 0;
        while (period_end !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        checkOutput("sync pe", period_end, 1);
    endtask

    function automatic logic [7:0] pickDuty();
        case ($urandom_range(0, 5))
            0:       return 8'd0;
            1:       return 8'd1;
            2:       return 8'hFF;
            3:       return 8'hFE;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    typedef struct {
        bit          rstV;
        bit          enV;
        bit          loadV;
        logic [31:0] dutyV;
        logic [3:0]  expDout;
        logic        expPe;
    } vec_t;

    localparam logic [31:0] DUTY_A = 32'hFF80_0100;   // {255,128,1,0}

    vec_t vecs[8];

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int n;
        int lowViol;

        rst         = 1'b1;
        en          = 1'b0;
        center_mode = 1'b0;
        duty_load   = 1'b0;
        duty_flat   = '0;
        mPos        = 0;
        mMode       = 1'b0;
        expDout     = '0;
        expPe       = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            mShadow[i] = 0;
            mActive[i] = 0;
        end

        // Reset beats enable and load; load while disabled; start-up counts.
        vecs[0] = '{1'b1, 1'b0, 1'b0, DUTY_A, 4'b0000, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, DUTY_A, 4'b0000, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, DUTY_A, 4'b0000, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, DUTY_A, 4'b0000, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, DUTY_A, 4'b0000, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, DUTY_A, 4'b1110, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, DUTY_A, 4'b1100, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, DUTY_A, 4'b1100, 1'b0};

        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k].rstV, vecs[k].enV, vecs[k].loadV, vecs[k].dutyV);
            checkOutput($sformatf("vec%0d dout", k), dout, vecs[k].expDout);
            checkOutput($sformatf("vec%0d pe", k), period_end, vecs[k].expPe);
        end
        duty_load = 1'b0;

        // Edge-mode cadence with duties {0,1,128,255}.
        syncToBoundary(300);
        runPeriod(256, -1, '0);
        checkPeriod("edge base", 256, 0, 1, 128, 256);

        // Mid-period load keeps the running pulse; boundary load applies at once.
        runPeriod(256, 50, 32'hFF40_0100);
        checkPeriod("load mid", 256, 0, 1, 128, 256);
        runPeriod(256, 255, 32'hFF20_0100);
        checkPeriod("after mid load", 256, 0, 1, 64, 256);

        // Center mode requested mid-period only starts at the boundary.
        center_mode = 1'b1;
        runPeriod(256, 255, 32'hFF64_0100);
        checkPeriod("boundary load", 256, 0, 1, 32, 256);
        center_mode = 1'b0;
        runPeriod(510, -1, '0);
        checkPeriod("center", 510, 0, 1, 199, 510);
        runPeriod(256, -1, '0);
        checkPeriod("back to edge", 256, 0, 1, 100, 256);

        // Drop enable at cnt=77, then restart a fresh period.
        for (int j = 0; j < 77; j++) tick();
        en = 1'b0;
        tick();
        checkOutput("en drop dout", dout, 0);
        checkOutput("en drop pe", period_end, 0);
        lowViol = 0;
        for (int j = 0; j < 9; j++) begin
            tick();
            if (dout !== '0 || period_end !== 1'b0) lowViol++;
        end
        checkOutput("en low quiet", lowViol, 0);
        en = 1'b1;
        runPeriod(256, -1, '0);
        checkPeriod("en restart", 256, 0, 1, 100, 256);

        // Mid-period reset clears duties; nothing drives high until reloaded.
        for (int j = 0; j < 30; j++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst dout", dout, 0);
        checkOutput("rst pe", period_end, 0);
        lowViol = 0;
        for (int j = 0; j < 600; j++) begin
            tick();
            if (dout !== '0) lowViol++;
        end
        checkOutput("rst stays low", lowViol, 0);
        duty_flat = 32'h281E_140A;
        duty_load = 1'b1;
        tick();
        duty_load = 1'b0;
        lowViol   = (dout !== '0) ? 1 : 0;
        n         = 0;
        while (period_end !== 1'b1 && n < 300) begin
            tick();
            if (dout !== '0) lowViol++;
            n++;
        end
        checkOutput("low until boundary", lowViol, 0);
        checkOutput("reload pe seen", period_end, 1);
        runPeriod(256, -1, '0);
        checkPeriod("after reset reload", 256, 10, 20, 30, 40);

        // Randomized run against the model.
        for (int k = 0; k < 4000; k++) begin
            rst       = ($urandom_range(0, 999) < 2);
            duty_load = 1'b0;
            if (!en) begin
                if ($urandom_range(0, 7) == 0) en = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                en = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                duty_load = 1'b1;
                duty_flat = {pickDuty(), pickDuty(), pickDuty(), pickDuty()};
            end
            if ($urandom_range(0, 149) == 0) center_mode = ~center_mode;
            tick();
            checkOutput($sformatf("rand dout c%0d", k), dout, expDout);
            checkOutput($sformatf("rand pe c%0d", k), period_end, expPe);
        end
        rst       = 1'b0;
        duty_load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
